// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small circular FIFO with push, pop and flush; carries {pc, inst} by default.
module ifetch_fifo import ifetch_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int WIDTH = XLEN + INST_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // DEPTH is a power of two, so the pointers wrap at DEPTH on their own.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // NOTE: storage is not reset; the head is forced to zero while empty instead.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// IF stage: owns the PC, streams word reads to imem, buffers {pc, inst} for decode.
// Optional `define IFETCH_STATS_EN adds fetch_cnt/redirect_cnt counters.
module ifetch_unit import ifetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instOut,
    output logic [XLEN-1:0]   pcOut,
    output logic              inst_valid,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       redirect_cnt
`endif
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     kill_q, kill_d;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     pending;
    logic [CW:0]       in_use;
    logic [XLEN-1:0]   rsp_pc;
    logic [XLEN+INST_W-1:0] head;
    logic              issue, rsp_accept, rsp_drop, pop;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign inst_valid = (fifo_count != '0);
    assign pop        = inst_valid && id_ready && !redirect;
    assign pending    = kill_q + outstanding;
    assign rsp_drop   = imem_rvalid && (pending != '0);
    // A slot freed by this cycle's pop is reusable at once, which sustains one fetch per cycle.
    assign in_use     = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        issue      = 1'b0;
        rsp_accept = 1'b0;
        case (state_q)
            RUN: if (!redirect) begin
                issue      = (in_use < DEPTH_W);
                rsp_accept = imem_rvalid && (outstanding != '0);
            end
            FLUSH: if (!redirect && imem_rvalid && (kill_q != '0)) kill_d = kill_q - CW'(1);
            default: ;
        endcase
        if (redirect) begin
            pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            kill_d = pending - CW'(rsp_drop);
        end else if (issue) begin
            pc_d = pc_q + PC_INC;
        end
        if (state_q == IDLE) state_d = RUN;
        else                 state_d = (kill_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    // Request PCs in issue order; its occupancy is the live outstanding count.
    ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_queue (
        .clock   (clock),
        .resetn  (resetn),
        .flush_i (redirect),
        .push_i  (issue),
        .data_i  (pc_q),
        .pop_i   (rsp_accept),
        .data_o  (rsp_pc),
        .count_o (outstanding)
    );

    ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + INST_W)) u_inst_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .flush_i (redirect),
        .push_i  (rsp_accept),
        .data_i  ({rsp_pc, imem_rdata}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count)
    );

    assign instOut = head[INST_W-1:0];
    assign pcOut   = head[XLEN+INST_W-1:INST_W];

`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt_q, redirect_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_q + 32'(pop);
            redirect_cnt_q <= redirect_cnt_q + 32'(redirect);
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

    rsp_expected_a: assert property (@(posedge clock) disable iff (!resetn)
        imem_rvalid |-> (pending != '0));

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit with an in-order latency memory model.
module tb_ifetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0400;
    localparam int          DEPTH = 2;

    logic        clock, resetn;
    logic        imem_req, imem_rvalid, inst_valid, id_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, instOut, pcOut, redirect_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt, redirect_cnt;
`endif

    ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instOut     (instOut),
        .pcOut       (pcOut),
        .inst_valid  (inst_valid),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFETCH_STATS_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    int n_redir = 0;
    int lat     = 1;
    int cyc     = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference stream: after reset or a redirect, decode must see base, base+4, ...
    task automatic load_expect(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(base + 32'(4 * i));
        exp_issue = base;
    endtask

    // Memory: in-order responses lat cycles after the request; entries live at a redirect go stale.
    initial begin
        bit deliver;
        int stale_n;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clock);
            cyc++;
            deliver     = resetn && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
            imem_rvalid = deliver;
            imem_rdata  = deliver ? mem_word(mem_q[0].addr) : $urandom;
            #1;
            if (resetn) begin
                stale_n = 0;
                foreach (mem_q[i]) if (mem_q[i].stale) stale_n++;
                if (stale_n > 0 || redirect) check("no_req_during_flush", imem_req, 0);
                if (redirect) foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                if (deliver) void'(mem_q.pop_front());
                if (imem_req) mem_q.push_back('{addr: imem_addr, due: cyc + lat, stale: 1'b0});
            end
        end
    end

    // Monitor: issue-address order, delivered {pc, inst} order, and stall stability.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_inst, prev_pc, e;
        prev_hold = 1'b0;
        prev_inst = '0;
        prev_pc   = '0;
        forever begin
            @(negedge clock);
            #1;
            if (!resetn) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                check("stall_inst", instOut, prev_inst);
                check("stall_pc", pcOut, prev_pc);
                check("stall_valid", inst_valid, 1);
            end
            if (imem_req) begin
                check("issue_addr", imem_addr, exp_issue);
                exp_issue = exp_issue + 32'd4;
            end
            if (inst_valid && id_ready && !redirect) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check("pop_expected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", pcOut, e);
                    check("pop_inst", instOut, mem_word(e));
                end
            end
            prev_hold = inst_valid && !id_ready && !redirect;
            prev_inst = instOut;
            prev_pc   = pcOut;
        end
    end

    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
        @(negedge clock);
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = tgt;
        if (redir) begin
            n_redir++;
            load_expect({tgt[31:2], 2'b00});
        end
        #2;
    endtask

    task automatic do_reset(input int new_lat);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RPC);
        check("rst_inst", instOut, 0);
        check("rst_pc", pcOut, 0);
        check("rst_valid", inst_valid, 0);
`ifdef IFETCH_STATS_EN
        check("rst_fetch_cnt", fetch_cnt, 0);
        check("rst_redirect_cnt", redirect_cnt, 0);
`endif
        mem_q.delete();
        lat = new_lat;
        load_expect(RPC);
        n_pops   = 0;
        n_redir  = 0;
        id_ready = 1'b0;
        redirect = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic check_stats();
`ifdef IFETCH_STATS_EN
        check("fetch_cnt", fetch_cnt, 32'(n_pops));
        check("redirect_cnt", redirect_cnt, 32'(n_redir));
`endif
    endtask

    task automatic wait_two_in_flight();
        int budget;
        budget = 0;
        while (mem_q.size() < 2 && budget < 30) begin
            cycle(1'b1, 1'b0, '0);
            budget++;
        end
        check("two_in_flight", mem_q.size(), 2);
    endtask

    initial begin
        int first, vcnt, reqs, p0;
        resetn      = 1'b1;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Streaming from RESET_PC with 1-cycle memory.
        do_reset(1);
        first = 0;
        vcnt  = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, '0);
            if (inst_valid) begin
                if (first == 0) first = i;
                vcnt++;
            end
        end
        check("first_valid_cycle", first, 3);
        check("sustained_valid_cycles", vcnt, 18);

        // Decode stall, then release.
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (imem_req) reqs++;
        end
        check("stall_req_bound", reqs <= DEPTH, 1);
        check("stall_head_valid", inst_valid, 1);
        p0 = n_pops;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);
        check("release_pops", (n_pops - p0) >= 8, 1);

        // PC wrap past 2^32, then random ready/redirect traffic.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFB);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        check_stats();

        // 3-cycle memory: redirect with two stale requests, then a second redirect mid-flush.
        do_reset(3);
        wait_two_in_flight();
        cycle(1'b1, 1'b1, 32'h0000_1000);
        p0 = n_pops;
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, '0);
        check("pops_after_redirect", (n_pops - p0) > 0, 1);
        wait_two_in_flight();
        cycle(1'b1, 1'b1, 32'h0000_1000);
        cycle(1'b1, 1'b1, 32'h0000_2002);
        p0 = n_pops;
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, '0);
        check("pops_after_second_redirect", (n_pops - p0) > 0, 1);
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
        check_stats();

        // Reset pulse while the FIFO is full and a fetch may be in flight.
        do_reset(1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
        check("full_before_reset", inst_valid, 1);
        check_stats();
        do_reset(1);
        p0 = n_pops;
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, '0);
        check("pops_after_reset", (n_pops - p0) > 0, 1);
        check_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

endmodule
